// File: rtl/insn_loader.sv
// insn_loader: boot-time loader that streams a length-prefixed, XOR-checksummed
// byte image into instruction memory as little-endian 32-bit words.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   in_valid      in_data holds a byte
//   in_data       stream byte (count lo, count hi, 4*N data bytes, checksum)
//   in_ready      a byte can be accepted this cycle (low once DONE/ERR)
//   mem_w         one-cycle write strobe into instruction memory
//   mem_addr      write address, BASE_ADDR + word index
//   mem_w_v       write data
//   done          image loaded and checksum matched
//   err           header count too large or checksum mismatch
//   words_loaded  number of words written since reset
module insn_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int unsigned MAX_WORDS = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_w,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_w_v,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);
    typedef enum logic [2:0] {HDR0, HDR1, DATA, CHK, DONE, ERR} state_t;

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [23:0] word_q, word_d;
    logic [7:0]  chk_q, chk_d;
    logic        mem_w_q, mem_w_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_w_v_q, mem_w_v_d;
    logic [15:0] n_hdr;
    logic        acc;

    assign in_ready     = (state_q != DONE) && (state_q != ERR);
    assign acc          = in_valid && in_ready;
    assign n_hdr        = {in_data, n_q[7:0]};
    assign mem_w        = mem_w_q;
    assign mem_addr     = mem_addr_q;
    assign mem_w_v      = mem_w_v_q;
    assign done         = (state_q == DONE);
    assign err          = (state_q == ERR);
    assign words_loaded = word_idx_q;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        chk_d      = chk_q;
        mem_w_d    = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_w_v_d  = mem_w_v_q;
        if (acc) begin
            // the checksum byte itself is compared, never folded in
            chk_d = (state_q == CHK) ? chk_q : chk_q ^ in_data;
            case (state_q)
                HDR0: begin
                    n_d[7:0] = in_data;
                    state_d  = HDR1;
                end
                HDR1: begin
                    n_d     = n_hdr;
                    state_d = (32'(n_hdr) > MAX_WORDS) ? ERR : (n_hdr == 16'd0) ? CHK : DATA;
                end
                DATA: begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    // low bytes arrive first, so shifting in from the top leaves them at the bottom
                    word_d     = {in_data, word_q[23:8]};
                    if (byte_idx_q == 2'd3) begin
                        mem_w_d    = 1'b1;
                        mem_w_v_d  = {in_data, word_q};
                        mem_addr_d = BASE_ADDR + 32'(word_idx_q);
                        word_idx_d = word_idx_q + 16'd1;
                        state_d    = (word_idx_d == n_q) ? CHK : DATA;
                    end
                end
                CHK:     state_d = (in_data == chk_q) ? DONE : ERR;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HDR0;
            n_q        <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            chk_q      <= '0;
            mem_w_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_w_v_q  <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            chk_q      <= chk_d;
            mem_w_q    <= mem_w_d;
            mem_addr_q <= mem_addr_d;
            mem_w_v_q  <= mem_w_v_d;
        end
    end
endmodule

// File: tb/tb_insn_loader.sv
// tb_insn_loader: table-driven and sequence checks for insn_loader
module tb_insn_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_w, done, err;
    logic [31:0] mem_addr, mem_w_v;
    logic [15:0] words_loaded;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic        r, v;
        logic [7:0]  d;
        logic        w;
        logic [31:0] a, wd;
        logic        dn, er, rd;
        logic [15:0] wl;
    } vec_t;
    vec_t vq[$];

    insn_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_w(mem_w), .mem_addr(mem_addr), .mem_w_v(mem_w_v), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, v, input logic [7:0] d, input logic w,
                       input logic [31:0] a, wd, input logic dn, er, rd, input logic [15:0] wl);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.w = w; x.a = a; x.wd = wd;
        x.dn = dn; x.er = er; x.rd = rd; x.wl = wl;
        vq.push_back(x);
    endtask

    task automatic add_rst();
        add(1, 1, 8'h02, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic add_stream(input logic [7:0] c, input logic good);
        add(0, 1, 8'h02, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'h13, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 8'hff, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'h00, 1, 0, 32'h13, 0, 0, 1, 1);
        add(0, 1, 8'hef, 0, 0, 32'h13, 0, 0, 1, 1);
        add(0, 1, 8'hbe, 0, 0, 32'h13, 0, 0, 1, 1);
        add(0, 1, 8'had, 0, 0, 32'h13, 0, 0, 1, 1);
        add(0, 1, 8'hde, 1, 1, 32'hdeadbeef, 0, 0, 1, 2);
        add(0, 1, c, 0, 1, 32'hdeadbeef, good, !good, 0, 2);
        add(0, 1, 8'h02, 0, 1, 32'hdeadbeef, good, !good, 0, 2);
    endtask

    task automatic step(input logic r, v, input logic [7:0] d);
        rst = r; in_valid = v; in_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] ea [2];
        logic [31:0] ed [2];
        logic [7:0]  s  [11];
        logic        prev;
        int          k;
        add_rst();
        add_stream(8'h33, 1);
        add_rst();
        add_stream(8'h34, 0);
        add_rst();
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 0, 1, 0, 0, 0);
        add_rst();
        add(0, 1, 8'h01, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'h10, 0, 0, 0, 0, 1, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 1, 0, 0);
        add_rst();
        add(0, 1, 8'h02, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'h13, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        add(1, 1, 8'h00, 0, 0, 0, 0, 0, 1, 0);
        add_stream(8'h33, 1);
        foreach (vq[i]) begin
            step(vq[i].r, vq[i].v, vq[i].d);
            chk($sformatf("vec%0d", i),
                128'({mem_w, mem_addr, mem_w_v, done, err, in_ready, words_loaded}),
                128'({vq[i].w, vq[i].a, vq[i].wd, vq[i].dn, vq[i].er, vq[i].rd, vq[i].wl}));
        end
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hef, 8'hbe, 8'had, 8'hde, 8'h33};
        ea = '{32'd0, 32'd1};
        ed = '{32'h13, 32'hdeadbeef};
        k = 0;
        prev = 1'b0;
        step(1, 0, 8'h00);
        for (int i = 0; i < 11; i++) begin
            int n = $urandom_range(5, 0);
            for (int j = 0; j <= n; j++) begin
                step(0, j == n, (j == n) ? s[i] : 8'(j * 37));
                if (mem_w && prev) chk("strobe_width", 128'(1), 128'(0));
                if (mem_w && k < 2) begin
                    chk($sformatf("stall_addr%0d", k), 128'(mem_addr), 128'(ea[k]));
                    chk($sformatf("stall_data%0d", k), 128'(mem_w_v), 128'(ed[k]));
                    k++;
                end else if (mem_w) chk("stall_extra_write", 128'(1), 128'(0));
                prev = mem_w;
            end
        end
        step(0, 0, 8'h00);
        chk("stall_writes", 128'(k), 128'(2));
        chk("stall_end", 128'({done, err, in_ready, words_loaded, mem_w}), 128'({3'b100, 16'd2, 1'b0}));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
